sy_ppl_btb_assoc: RTL and testbench

//   Set-associative, tagged branch target buffer for the fronted branch predictor.

---
 rtl/sy_ppl_btb_assoc_if.sv | 35 +++
 rtl/sy_ppl_btb_assoc.sv | 132 +++++++++++++
 tb/tb_sy_ppl_btb_assoc.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/sy_ppl_btb_assoc_if.sv
// Fetch/retire side of the associative BTB: lookup, update/kill and
// flush inputs plus the registered prediction outputs.
interface sy_ppl_btb_assoc_if #(
  parameter int AWTH     = 32,
  parameter int NUM_WAYS = 4
);
  localparam int WAY_WTH = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  logic               flush_i;
  logic               req_i;
  logic [AWTH-1:0]    vaddr_i;
  logic               upd_vld_i;
  logic               upd_kill_i;
  logic [AWTH-1:0]    upd_pc_i;
  logic [AWTH-1:0]    upd_target_i;
  logic               pred_vld_o;
  logic [AWTH-1:0]    pred_target_o;
  logic [WAY_WTH-1:0] pred_way_o;

  modport master (
    output flush_i, req_i, vaddr_i,
    output upd_vld_i, upd_kill_i,
    output upd_pc_i, upd_target_i,
    input  pred_vld_o, pred_target_o,
    input  pred_way_o
  );

  modport slave (
    input  flush_i, req_i, vaddr_i,
    input  upd_vld_i, upd_kill_i,
    input  upd_pc_i, upd_target_i,
    output pred_vld_o, pred_target_o,
    output pred_way_o
  );
endinterface

// File: rtl/sy_ppl_btb_assoc.sv
// Set-associative partial-tag BTB with flop storage and a per-set
// round-robin victim pointer; one-cycle lookup, one update per cycle.
module sy_ppl_btb_assoc #(
  parameter int NUM_SETS = 64,
  parameter int NUM_WAYS = 4,
  parameter int TAG_WTH  = 12,
  parameter int IDX_LSB  = 1,
  parameter int AWTH     = 32
) (
  input logic clk_i,
  input logic rst_i,
  sy_ppl_btb_assoc_if.slave bus
);
  localparam int SET_WTH = $clog2(NUM_SETS);
  localparam int WAY_WTH = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int TAG_LSB = IDX_LSB + SET_WTH;

  logic [NUM_WAYS-1:0] vld_q [NUM_SETS];
  logic [TAG_WTH-1:0]  tag_q [NUM_SETS][NUM_WAYS];
  logic [AWTH-1:0]     tgt_q [NUM_SETS][NUM_WAYS];
  logic [WAY_WTH-1:0]  rr_q  [NUM_SETS];

  logic [SET_WTH-1:0] lk_set, up_set;
  logic [TAG_WTH-1:0] lk_tag, up_tag;
  logic               lk_hit, up_hit, up_inv;
  logic [WAY_WTH-1:0] lk_way, up_hit_way;
  logic [WAY_WTH-1:0] up_inv_way, up_way;
  logic [WAY_WTH-1:0] rr_nxt;
  logic               wr_en, kill_en, rr_adv;

  logic               pvld_q;
  logic [AWTH-1:0]    ptgt_q;
  logic [WAY_WTH-1:0] pway_q;

  logic unused_pc;
  assign unused_pc = ^{bus.vaddr_i, bus.upd_pc_i};

  assign lk_set = bus.vaddr_i[IDX_LSB +: SET_WTH];
  assign lk_tag = bus.vaddr_i[TAG_LSB +: TAG_WTH];
  assign up_set = bus.upd_pc_i[IDX_LSB +: SET_WTH];
  assign up_tag = bus.upd_pc_i[TAG_LSB +: TAG_WTH];

  // Descending scan so the lowest-index match wins.
  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (vld_q[lk_set][w] && tag_q[lk_set][w] == lk_tag) begin
        lk_hit = 1'b1;
        lk_way = WAY_WTH'(w);
      end
    end
  end

  always_comb begin
    up_hit     = 1'b0;
    up_hit_way = '0;
    up_inv     = 1'b0;
    up_inv_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (vld_q[up_set][w] && tag_q[up_set][w] == up_tag) begin
        up_hit     = 1'b1;
        up_hit_way = WAY_WTH'(w);
      end
      if (!vld_q[up_set][w]) begin
        up_inv     = 1'b1;
        up_inv_way = WAY_WTH'(w);
      end
    end
  end

  always_comb begin
    up_way = rr_q[up_set];
    if (up_hit)
      up_way = up_hit_way;
    else if (up_inv)
      up_way = up_inv_way;
  end

  assign wr_en   = bus.upd_vld_i & ~bus.upd_kill_i & ~bus.flush_i;
  assign kill_en = bus.upd_vld_i & bus.upd_kill_i
                 & up_hit & ~bus.flush_i;
  assign rr_adv  = wr_en & ~up_hit & ~up_inv;
  assign rr_nxt  = (rr_q[up_set] == WAY_WTH'(NUM_WAYS - 1))
                 ? '0 : rr_q[up_set] + WAY_WTH'(1);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        vld_q[s] <= '0;
        rr_q[s]  <= '0;
      end
    end else if (bus.flush_i) begin
      for (int s = 0; s < NUM_SETS; s++)
        vld_q[s] <= '0;
    end else begin
      if (wr_en)
        vld_q[up_set][up_way] <= 1'b1;
      if (kill_en)
        vld_q[up_set][up_hit_way] <= 1'b0;
      if (rr_adv)
        rr_q[up_set] <= rr_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      tag_q[up_set][up_way] <= up_tag;
      tgt_q[up_set][up_way] <= bus.upd_target_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pvld_q <= 1'b0;
      ptgt_q <= '0;
      pway_q <= '0;
    end else if (bus.flush_i) begin
      pvld_q <= 1'b0;
      ptgt_q <= '0;
      pway_q <= '0;
    end else if (bus.req_i) begin
      pvld_q <= lk_hit;
      ptgt_q <= lk_hit ? tgt_q[lk_set][lk_way] : '0;
      pway_q <= lk_hit ? lk_way : '0;
    end
  end

  assign bus.pred_vld_o    = pvld_q;
  assign bus.pred_target_o = ptgt_q;
  assign bus.pred_way_o    = pway_q;
endmodule

// File: tb/tb_sy_ppl_btb_assoc.sv
// Directed scoreboard bench for the associative BTB.
module tb_sy_ppl_btb_assoc;
  logic clk;
  logic rst_n;
  int   n_run;
  int   n_fail;

  typedef struct {
    logic        v;
    logic [31:0] t;
    logic [1:0]  w;
    bit          full;
  } exp_t;

  exp_t q[$];

  sy_ppl_btb_assoc_if #(.AWTH(32), .NUM_WAYS(4)) bus();

  sy_ppl_btb_assoc #(
    .NUM_SETS(64), .NUM_WAYS(4), .TAG_WTH(12),
    .IDX_LSB(1), .AWTH(32)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    n_run++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] pc1(input int t);
    return (32'(t) << 7) | 32'h2;
  endfunction

  task automatic step(input logic rq, input logic [31:0] va,
                      input logic uv, input logic uk,
                      input logic [31:0] up, input logic [31:0] ut,
                      input logic fl, input logic ev,
                      input logic [31:0] et, input logic [1:0] ew,
                      input bit full);
    exp_t e;
    @(negedge clk);
    bus.req_i        = rq;
    bus.vaddr_i      = va;
    bus.upd_vld_i    = uv;
    bus.upd_kill_i   = uk;
    bus.upd_pc_i     = up;
    bus.upd_target_i = ut;
    bus.flush_i      = fl;
    if (rq || fl) begin
      e.v = ev; e.t = et; e.w = ew; e.full = full;
      q.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic lk(input logic [31:0] va, input logic ev,
                    input logic [31:0] et, input logic [1:0] ew);
    step(1, va, 0, 0, 0, 0, 0, ev, et, ew, 1);
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tg);
    step(0, 0, 1, 0, pc, tg, 0, 0, 0, 0, 1);
  endtask

  task automatic kil(input logic [31:0] pc);
    step(0, 0, 1, 1, pc, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  // Monitor: an output is due after every edge that saw req or flush.
  initial begin
    int  k;
    bit  fire;
    exp_t e;
    k = 0;
    forever begin
      @(posedge clk);
      fire = rst_n && (bus.req_i || bus.flush_i);
      #1;
      if (fire) begin
        if (q.size() == 0) begin
          chk("unexpected output", 1, 0);
        end else begin
          e = q.pop_front();
          chk($sformatf("lk%0d vld", k), 64'(bus.pred_vld_o), 64'(e.v));
          if (e.full) begin
            chk($sformatf("lk%0d tgt", k),
                64'(bus.pred_target_o), 64'(e.t));
            chk($sformatf("lk%0d way", k),
                64'(bus.pred_way_o), 64'(e.w));
          end
          k++;
        end
      end
    end
  end

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.req_i = 0; bus.vaddr_i = 0; bus.flush_i = 0;
    bus.upd_vld_i = 0; bus.upd_kill_i = 0;
    bus.upd_pc_i = 0; bus.upd_target_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst vld", 64'(bus.pred_vld_o), 0);
    chk("rst tgt", 64'(bus.pred_target_o), 0);
    chk("rst way", 64'(bus.pred_way_o), 0);
    @(negedge clk);
    rst_n = 1'b1;

    lk(32'h1000, 0, 0, 0);
    upd(32'h1000, 32'h2000);
    lk(32'h1000, 1, 32'h2000, 0);
    lk(32'h81000, 1, 32'h2000, 0);
    lk(32'h1080, 0, 0, 0);

    for (int t = 1; t <= 6; t++)
      upd(pc1(t), 32'h4000 + 32'(t) * 32'h10);
    lk(pc1(5), 1, 32'h4050, 0);
    lk(pc1(6), 1, 32'h4060, 1);
    lk(pc1(3), 1, 32'h4030, 2);
    lk(pc1(4), 1, 32'h4040, 3);
    lk(pc1(1), 0, 0, 0);
    lk(pc1(2), 0, 0, 0);

    kil(pc1(3));
    lk(pc1(3), 0, 0, 0);
    upd(pc1(7), 32'h4070);
    lk(pc1(7), 1, 32'h4070, 2);
    upd(pc1(8), 32'h4080);
    lk(pc1(8), 1, 32'h4080, 2);
    lk(pc1(7), 0, 0, 0);
    lk(pc1(5), 1, 32'h4050, 0);
    kil(pc1(1));
    lk(pc1(4), 1, 32'h4040, 3);
    lk(pc1(6), 1, 32'h4060, 1);

    step(1, 32'h1000, 1, 0, 32'h1000, 32'h3000, 0,
         1, 32'h2000, 0, 1);
    lk(32'h1000, 1, 32'h3000, 0);
    idle();
    #2;
    chk("hold vld", 64'(bus.pred_vld_o), 1);
    chk("hold tgt", 64'(bus.pred_target_o), 64'h3000);

    step(1, 32'h1000, 1, 0, 32'h1080, 32'h5000, 1,
         0, 0, 0, 0);
    lk(32'h1000, 0, 0, 0);
    lk(32'h1080, 0, 0, 0);
    lk(pc1(4), 0, 0, 0);

    upd(32'h1000, 32'h2000);
    lk(32'h1000, 1, 32'h2000, 0);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst vld", 64'(bus.pred_vld_o), 0);
    chk("async rst tgt", 64'(bus.pred_target_o), 0);
    chk("async rst way", 64'(bus.pred_way_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    lk(32'h1000, 0, 0, 0);

    idle();
    repeat (2) @(posedge clk);
    #3;
    chk("queue drained", 64'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
